// File: rtl/mem_pkg.sv
// Shared definitions for the two-port RAM arbiter: command encodings,
// ownership states and default bus widths.
package mem_pkg;

    localparam int AW_DEF = 9;
    localparam int DW_DEF = 16;

    localparam logic [1:0] MNONE    = 2'b00;
    localparam logic [1:0] MREAD    = 2'b01;
    localparam logic [1:0] MWRITE   = 2'b10;
    localparam logic [1:0] MILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } own_state_t;

    function automatic logic is_req(input logic [1:0] cmd);
        return (cmd == MREAD) || (cmd == MWRITE);
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way chooser: round-robin on the last grant, or fixed
// priority with port 0 winning. Output is one-hot or zero.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       fixed,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        // Contention: port 0 wins under fixed priority or when port 1 went last.
        if (req == 2'b11) begin
            gnt = (fixed || last) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a single-port RAM between two requesters with combinational
// grants, 1-cycle read return, optional bus lock and a sticky error flag.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int AW         = AW_DEF,
    parameter int DW         = DW_DEF,
    parameter int FIXED_PRIO = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    cmd0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    input  logic          lock0,
    output logic          gnt0,
    output logic          rvalid0,
    output logic [DW-1:0] rdata0,
    input  logic [1:0]    cmd1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    input  logic          lock1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout,
    output logic          err
);

    own_state_t    state_reg, state_next;
    logic          last_reg;
    logic [1:0]    rvalid_reg;
    logic          err_reg;
    logic [AW-1:0] ram_addr_reg;

    logic [1:0]    eligible;
    logic [1:0]    gnt_vec;
    logic [1:0]    rd_gnt;

    // State register, last-grant pointer, read-return pipeline and error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            last_reg     <= 1'b1;
            rvalid_reg   <= 2'b00;
            err_reg      <= 1'b0;
            ram_addr_reg <= '0;
        end else begin
            state_reg    <= state_next;
            rvalid_reg   <= rd_gnt;
            ram_addr_reg <= ram_addr;
            err_reg      <= err_reg | (cmd0 == MILLEGAL) | (cmd1 == MILLEGAL);
            if (|gnt_vec) begin
                last_reg <= gnt_vec[1];
            end
        end
    end

    // A held lock masks the other port; a falling lock re-arbitrates at once.
    always_comb begin
        eligible = {is_req(cmd1), is_req(cmd0)};
        case (state_reg)
            OWN0:    if (lock0) eligible = {1'b0, is_req(cmd0)};
            OWN1:    if (lock1) eligible = {is_req(cmd1), 1'b0};
            default: ;
        endcase
        if (!reset) begin
            eligible = 2'b00;
        end
    end

    rr_pick2 u_pick (
        .req   (eligible),
        .last  (last_reg),
        .fixed (FIXED_PRIO != 0),
        .gnt   (gnt_vec)
    );

    always_comb begin
        state_next = IDLE;
        case (state_reg)
            OWN0:    if (lock0) state_next = OWN0;
            OWN1:    if (lock1) state_next = OWN1;
            default: state_next = IDLE;
        endcase
        if (gnt_vec[0] && lock0) begin
            state_next = OWN0;
        end else if (gnt_vec[1] && lock1) begin
            state_next = OWN1;
        end
    end

    always_comb begin
        gnt0     = gnt_vec[0];
        gnt1     = gnt_vec[1];
        ram_addr = ram_addr_reg;
        ram_we   = 1'b0;
        ram_din  = '0;
        rd_gnt   = gnt_vec & {cmd1 == MREAD, cmd0 == MREAD};
        if (gnt_vec[1]) begin
            ram_addr = addr1;
            ram_we   = (cmd1 == MWRITE);
            ram_din  = wdata1;
        end else if (gnt_vec[0]) begin
            ram_addr = addr0;
            ram_we   = (cmd0 == MWRITE);
            ram_din  = wdata0;
        end
    end

    assign rvalid0 = rvalid_reg[0];
    assign rvalid1 = rvalid_reg[1];
    assign rdata0  = rvalid_reg[0] ? ram_dout : '0;
    assign rdata1  = rvalid_reg[1] ? ram_dout : '0;
    assign err     = err_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: round-robin instance with a RAM model,
// plus a fixed-priority instance sharing the same stimulus.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  cmd0, cmd1;
    logic [8:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        lock0, lock1;

    logic        gnt0, gnt1, rvalid0, rvalid1, ram_we, err;
    logic [15:0] rdata0, rdata1, ram_din;
    logic [15:0] ram_dout;
    logic [8:0]  ram_addr;

    logic        gnt0_f, gnt1_f, rvalid0_f, rvalid1_f, ram_we_f, err_f;
    logic [15:0] rdata0_f, rdata1_f, ram_din_f;
    logic [15:0] ram_dout_f;
    logic [8:0]  ram_addr_f;

    logic [15:0] ram     [0:511];
    logic [15:0] exp_mem [0:511];

    typedef struct packed {
        logic        port;
        logic [15:0] data;
    } sb_t;
    sb_t sb[$];

    int   checks   = 0;
    int   failures = 0;
    logic err_exp  = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(9), .DW(16), .FIXED_PRIO(0)) dut (
        .clk(clk), .reset(reset),
        .cmd0(cmd0), .addr0(addr0), .wdata0(wdata0), .lock0(lock0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .cmd1(cmd1), .addr1(addr1), .wdata1(wdata1), .lock1(lock1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din),
        .ram_dout(ram_dout), .err(err)
    );

    mem_arbiter #(.AW(9), .DW(16), .FIXED_PRIO(1)) dut_f (
        .clk(clk), .reset(reset),
        .cmd0(cmd0), .addr0(addr0), .wdata0(wdata0), .lock0(lock0),
        .gnt0(gnt0_f), .rvalid0(rvalid0_f), .rdata0(rdata0_f),
        .cmd1(cmd1), .addr1(addr1), .wdata1(wdata1), .lock1(lock1),
        .gnt1(gnt1_f), .rvalid1(rvalid1_f), .rdata1(rdata1_f),
        .ram_addr(ram_addr_f), .ram_we(ram_we_f), .ram_din(ram_din_f),
        .ram_dout(ram_dout_f), .err(err_f)
    );

    assign ram_dout_f = 16'h0;

    // Registered-output RAM shared by the round-robin instance.
    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_din;
        ram_dout <= ram[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check the return of last cycle's read, check grant.
    task automatic do_cycle(
        input logic [1:0] c0, input logic [8:0] a0, input logic [15:0] w0, input logic l0,
        input logic [1:0] c1, input logic [8:0] a1, input logic [15:0] w1, input logic l1,
        input logic [1:0] eg, input logic chk_f, input logic [1:0] eg_f
    );
        sb_t         e;
        logic [1:0]  exp_rv;
        logic [15:0] exp_rd0, exp_rd1;
        logic        exp_we;
        cmd0 = c0; addr0 = a0; wdata0 = w0; lock0 = l0;
        cmd1 = c1; addr1 = a1; wdata1 = w1; lock1 = l1;
        #1;
        exp_rv = 2'b00; exp_rd0 = 16'h0; exp_rd1 = 16'h0;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.port) begin exp_rv[1] = 1'b1; exp_rd1 = e.data; end
            else        begin exp_rv[0] = 1'b1; exp_rd0 = e.data; end
        end
        check("rvalid", {30'd0, rvalid1, rvalid0}, {30'd0, exp_rv});
        check("rdata0", {16'd0, rdata0}, {16'd0, exp_rd0});
        check("rdata1", {16'd0, rdata1}, {16'd0, exp_rd1});
        check("gnt", {30'd0, gnt1, gnt0}, {30'd0, eg});
        exp_we = (eg[0] && c0 == 2'b10) || (eg[1] && c1 == 2'b10);
        check("ram_we", {31'd0, ram_we}, {31'd0, exp_we});
        check("err", {31'd0, err}, {31'd0, err_exp});
        if (eg[0]) begin
            check("ram_addr", {23'd0, ram_addr}, {23'd0, a0});
            if (c0 == 2'b01) sb.push_back('{port: 1'b0, data: exp_mem[a0]});
            if (c0 == 2'b10) begin
                check("ram_din", {16'd0, ram_din}, {16'd0, w0});
                exp_mem[a0] = w0;
            end
        end
        if (eg[1]) begin
            check("ram_addr", {23'd0, ram_addr}, {23'd0, a1});
            if (c1 == 2'b01) sb.push_back('{port: 1'b1, data: exp_mem[a1]});
            if (c1 == 2'b10) begin
                check("ram_din", {16'd0, ram_din}, {16'd0, w1});
                exp_mem[a1] = w1;
            end
        end
        if (chk_f) begin
            check("gnt_fixed", {30'd0, gnt1_f, gnt0_f}, {30'd0, eg_f});
            check("ram_we_fixed", {31'd0, ram_we_f}, 32'd0);
        end
        @(posedge clk);
        #1;
        if (c0 == 2'b11 || c1 == 2'b11) err_exp = 1'b1;
        $display("cycle t=%0t cmd0=%b cmd1=%b lock=%b%b gnt=%b%b rvalid=%b%b err=%b",
                 $time, c0, c1, l1, l0, gnt1, gnt0, rvalid1, rvalid0, err);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_gnt"}, {30'd0, gnt1, gnt0}, 32'd0);
        check({tag, "_rvalid"}, {30'd0, rvalid1, rvalid0}, 32'd0);
        check({tag, "_err"}, {31'd0, err}, 32'd0);
        check({tag, "_ram_we"}, {31'd0, ram_we}, 32'd0);
        check({tag, "_ram_addr"}, {23'd0, ram_addr}, 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        cmd0 = 2'b01; addr0 = 9'h0; wdata0 = 16'h0; lock0 = 1'b0;
        cmd1 = 2'b01; addr1 = 9'h0; wdata1 = 16'h0; lock1 = 1'b0;
        #2;
        check_reset_state("por");
        @(posedge clk); #1;
        reset = 1'b1;
        cmd0 = 2'b00; cmd1 = 2'b00;

        // Preload through port 1 (pointer stays at port 1).
        do_cycle(2'b00, 9'h0, 16'h0, 0, 2'b10, 9'h010, 16'hA010, 0, 2'b10, 0, 2'b00);
        do_cycle(2'b00, 9'h0, 16'h0, 0, 2'b10, 9'h011, 16'hA011, 0, 2'b10, 0, 2'b00);
        do_cycle(2'b00, 9'h0, 16'h0, 0, 2'b10, 9'h012, 16'hA012, 0, 2'b10, 0, 2'b00);
        do_cycle(2'b00, 9'h0, 16'h0, 0, 2'b10, 9'h013, 16'hA013, 0, 2'b10, 0, 2'b00);

        // Round-robin with both ports reading every cycle.
        do_cycle(2'b01, 9'h010, 16'h0, 0, 2'b01, 9'h012, 16'h0, 0, 2'b01, 0, 2'b00);
        do_cycle(2'b01, 9'h011, 16'h0, 0, 2'b01, 9'h012, 16'h0, 0, 2'b10, 0, 2'b00);
        do_cycle(2'b01, 9'h011, 16'h0, 0, 2'b01, 9'h013, 16'h0, 0, 2'b01, 0, 2'b00);
        do_cycle(2'b01, 9'h010, 16'h0, 0, 2'b01, 9'h013, 16'h0, 0, 2'b10, 0, 2'b00);

        // Port 0 write then read-back.
        do_cycle(2'b10, 9'h005, 16'h1234, 0, 2'b00, 9'h0, 16'h0, 0, 2'b01, 0, 2'b00);
        do_cycle(2'b01, 9'h005, 16'h0, 0, 2'b00, 9'h0, 16'h0, 0, 2'b01, 0, 2'b00);

        // Port 1 locks the bus for three reads while port 0 waits.
        do_cycle(2'b01, 9'h010, 16'h0, 0, 2'b01, 9'h011, 16'h0, 1, 2'b10, 0, 2'b00);
        do_cycle(2'b01, 9'h010, 16'h0, 0, 2'b01, 9'h012, 16'h0, 1, 2'b10, 0, 2'b00);
        do_cycle(2'b01, 9'h010, 16'h0, 0, 2'b01, 9'h013, 16'h0, 1, 2'b10, 0, 2'b00);
        do_cycle(2'b01, 9'h010, 16'h0, 0, 2'b00, 9'h0, 16'h0, 0, 2'b01, 0, 2'b00);

        // Illegal command on port 0; port 1 keeps working.
        do_cycle(2'b11, 9'h007, 16'h0, 0, 2'b01, 9'h012, 16'h0, 0, 2'b10, 0, 2'b00);
        do_cycle(2'b00, 9'h0, 16'h0, 0, 2'b10, 9'h020, 16'hBEEF, 0, 2'b10, 0, 2'b00);
        do_cycle(2'b00, 9'h0, 16'h0, 0, 2'b01, 9'h020, 16'h0, 0, 2'b10, 0, 2'b00);
        do_cycle(2'b00, 9'h0, 16'h0, 0, 2'b00, 9'h0, 16'h0, 0, 2'b00, 0, 2'b00);

        // Reset asserted the cycle after a read grant.
        do_cycle(2'b01, 9'h005, 16'h0, 0, 2'b00, 9'h0, 16'h0, 0, 2'b01, 0, 2'b00);
        reset = 1'b0;
        #1;
        check_reset_state("rst_mid");
        sb.delete();
        err_exp = 1'b0;
        @(posedge clk); #1;
        check_reset_state("rst_hold");
        reset = 1'b1;
        do_cycle(2'b00, 9'h0, 16'h0, 0, 2'b00, 9'h0, 16'h0, 0, 2'b00, 0, 2'b00);

        // Both ports reading; fixed-priority instance always favours port 0.
        do_cycle(2'b01, 9'h010, 16'h0, 0, 2'b01, 9'h011, 16'h0, 0, 2'b01, 1, 2'b01);
        do_cycle(2'b01, 9'h010, 16'h0, 0, 2'b01, 9'h011, 16'h0, 0, 2'b10, 1, 2'b01);
        do_cycle(2'b01, 9'h010, 16'h0, 0, 2'b01, 9'h011, 16'h0, 0, 2'b01, 1, 2'b01);
        do_cycle(2'b00, 9'h0, 16'h0, 0, 2'b01, 9'h011, 16'h0, 0, 2'b10, 1, 2'b10);
        do_cycle(2'b00, 9'h0, 16'h0, 0, 2'b00, 9'h0, 16'h0, 0, 2'b00, 1, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
